// File: rtl/rtc_pkg.sv
// Shared constants and field encodings for the hour/minute/second RTC core.
// Includes the range check used to accept or reject field-set requests.
package rtc_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'b00,
        FIELD_MIN  = 2'b01,
        FIELD_HOUR = 2'b10,
        FIELD_RSVD = 2'b11
    } field_e;

    localparam logic [SEC_W-1:0]  SEC_MAX    = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX    = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR24_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] HOUR12_MIN = 5'd1;
    localparam logic [HOUR_W-1:0] HOUR12_MAX = 5'd12;

    // Full 6-bit comparison: an out-of-range hour must never alias into range by truncation.
    function automatic logic set_in_range(field_e f, logic [5:0] v, logic mode12);
        logic ok;
        ok = 1'b0;
        case (f)
            FIELD_SEC:  ok = (v <= SEC_MAX);
            FIELD_MIN:  ok = (v <= MIN_MAX);
            FIELD_HOUR: ok = mode12 ? ((v >= {1'b0, HOUR12_MIN}) && (v <= {1'b0, HOUR12_MAX}))
                                    : (v <= {1'b0, HOUR24_MAX});
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the board clock down to a registered 1 Hz tick; holds while run=0.
// wrap is the combinational terminal-count condition the counters advance on.
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic wrap,
    output logic tick
);

    localparam int unsigned    PW = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0]  TC = PW'(CLK_FREQ_HZ - 1);

    logic [PW-1:0] count;

    assign wrap = run && !clear && (count == TC);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            if (run) begin
                count <= (count == TC) ? '0 : count + PW'(1);
            end
            tick <= wrap;
        end
    end

endmodule

// File: rtl/rtc_hms_core.sv
// Real-time clock core: prescaler, cascaded sec/min/hour counters, field set port, 12/24h mode.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_hms_core
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter bit          MODE_12H    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              set_valid,
    input  logic [1:0]        set_field,
    input  logic [5:0]        set_value,
    output logic              set_err,
    output logic              tick_1hz,
    output logic [SEC_W-1:0]  seconds_out,
    output logic [MIN_W-1:0]  minutes_out,
    output logic [HOUR_W-1:0] hours_out,
    output logic              pm_out
`ifdef RTC_ALARM_EN
    ,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    input  logic              alarm_pm,
    output logic              alarm_hit
`endif
);

    localparam logic [HOUR_W-1:0] HOUR_RST = MODE_12H ? HOUR12_MAX : '0;

    field_e            field;
    logic              set_acc;
    logic              wrap;
    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [MIN_W-1:0]  min_q,  min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              pm_q,   pm_d;
    logic              err_q;

    assign field   = field_e'(set_field);
    assign set_acc = set_valid && set_in_range(field, set_value, MODE_12H);

    rtc_prescaler #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .clear(set_acc),
        .wrap (wrap),
        .tick (tick_1hz)
    );

    // An accepted set takes precedence over the carry chain, so wrap is already masked by clear.
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        pm_d   = pm_q;
        if (set_acc) begin
            case (field)
                FIELD_SEC:  sec_d  = set_value;
                FIELD_MIN:  min_d  = set_value;
                FIELD_HOUR: hour_d = set_value[HOUR_W-1:0];
                default:    ;
            endcase
        end else if (wrap) begin
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                    min_d = '0;
                    if (MODE_12H) begin
                        // 12h order is 12,1..11; the pm flag flips entering 12.
                        if (hour_q == HOUR12_MAX) begin
                            hour_d = HOUR12_MIN;
                        end else begin
                            hour_d = hour_q + HOUR_W'(1);
                            if (hour_q == HOUR12_MAX - HOUR_W'(1)) pm_d = !pm_q;
                        end
                    end else begin
                        hour_d = (hour_q == HOUR24_MAX) ? '0 : hour_q + HOUR_W'(1);
                    end
                end else begin
                    min_d = min_q + MIN_W'(1);
                end
            end else begin
                sec_d = sec_q + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= HOUR_RST;
            pm_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            pm_q   <= pm_d;
            err_q  <= set_valid && !set_acc;
        end
    end

    assign set_err     = err_q;
    assign seconds_out = sec_q;
    assign minutes_out = min_q;
    assign hours_out   = hour_q;
    assign pm_out      = MODE_12H ? pm_q : 1'b0;

`ifdef RTC_ALARM_EN
    logic alarm_match;
    logic alarm_q;

    assign alarm_match = alarm_en && (set_acc || wrap) && (sec_d == '0)
                      && (min_d == alarm_minutes) && (hour_d == alarm_hours)
                      && (!MODE_12H || (pm_d == alarm_pm));

    always_ff @(posedge clk) begin
        if (reset) alarm_q <= 1'b0;
        else       alarm_q <= alarm_match;
    end

    assign alarm_hit = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_hms_core.sv
// Scoreboard bench: 24h and 12h instances share stimulus; a time-of-day model predicts outputs.
module tb_rtc_hms_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0, run = 1'b0, set_valid = 1'b0;
    logic [1:0] set_field = '0;
    logic [5:0] set_value = '0;

    logic       err24, tick24, pm24, err12, tick12, pm12;
    logic [5:0] sec24, min24, sec12, min12;
    logic [4:0] hr24, hr12;

    always #5 clk = ~clk;

`ifdef RTC_ALARM_EN
    logic ah24, ah12;
`endif

    rtc_hms_core #(.CLK_FREQ_HZ(4), .MODE_12H(1'b0)) dut24 (
        .clk(clk), .reset(reset), .run(run), .set_valid(set_valid),
        .set_field(set_field), .set_value(set_value), .set_err(err24),
        .tick_1hz(tick24), .seconds_out(sec24), .minutes_out(min24),
        .hours_out(hr24), .pm_out(pm24)
`ifdef RTC_ALARM_EN
        , .alarm_en(1'b0), .alarm_hours(5'd0), .alarm_minutes(6'd0),
        .alarm_pm(1'b0), .alarm_hit(ah24)
`endif
    );

    rtc_hms_core #(.CLK_FREQ_HZ(4), .MODE_12H(1'b1)) dut12 (
        .clk(clk), .reset(reset), .run(run), .set_valid(set_valid),
        .set_field(set_field), .set_value(set_value), .set_err(err12),
        .tick_1hz(tick12), .seconds_out(sec12), .minutes_out(min12),
        .hours_out(hr12), .pm_out(pm12)
`ifdef RTC_ALARM_EN
        , .alarm_en(1'b0), .alarm_hours(5'd0), .alarm_minutes(6'd0),
        .alarm_pm(1'b0), .alarm_hit(ah12)
`endif
    );

    typedef struct {
        int tick; int err; int sec; int min; int hr; int pm;
    } exp_t;

    exp_t q24[$];
    exp_t q12[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: seconds since midnight and prescaler phase, per instance (0=24h, 1=12h).
    int mt[2];
    int mp[2];

    function automatic bit in_range(int f, int v, bit m12);
        if (f == 0 || f == 1) return v <= 59;
        if (f == 2) return m12 ? (v >= 1 && v <= 12) : (v <= 23);
        return 1'b0;
    endfunction

    function automatic exp_t view(int i, int tk, int er);
        exp_t e;
        int h;
        h = mt[i] / 3600;
        e.tick = tk;
        e.err  = er;
        e.sec  = mt[i] % 60;
        e.min  = (mt[i] / 60) % 60;
        if (i == 0) begin
            e.hr = h;
            e.pm = 0;
        end else begin
            e.hr = (h % 12 == 0) ? 12 : h % 12;
            e.pm = (h >= 12) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(bit rst, bit rn, bit sv, bit [1:0] sf, bit [5:0] val);
        @(negedge clk);
        reset = rst; run = rn; set_valid = sv; set_field = sf; set_value = val;
        for (int i = 0; i < 2; i++) begin
            int tk, er, h24, mi, s;
            tk = 0; er = 0;
            if (rst) begin
                mt[i] = 0; mp[i] = 0;
            end else if (sv && in_range(sf, val, i == 1)) begin
                h24 = mt[i] / 3600; mi = (mt[i] / 60) % 60; s = mt[i] % 60;
                if (sf == 0) s = val;
                else if (sf == 1) mi = val;
                else if (i == 0) h24 = val;
                else h24 = (val % 12) + ((h24 >= 12) ? 12 : 0);
                mt[i] = h24 * 3600 + mi * 60 + s;
                mp[i] = 0;
            end else begin
                er = sv ? 1 : 0;
                if (rn) begin
                    if (mp[i] == 3) begin
                        mp[i] = 0; tk = 1; mt[i] = (mt[i] + 1) % 86400;
                    end else begin
                        mp[i] = mp[i] + 1;
                    end
                end
            end
            if (i == 0) q24.push_back(view(0, tk, er));
            else        q12.push_back(view(1, tk, er));
        end
    endtask

    task automatic set_time(int h, int m, int s);
        step(0, 0, 1, 2'd2, 6'(h));
        step(0, 0, 1, 2'd1, 6'(m));
        step(0, 0, 1, 2'd0, 6'(s));
    endtask

    // Monitor: outputs are registered, so every cycle presents a new response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q24.size() > 0) begin
                e = q24.pop_front();
                chk("tick24", int'(tick24), e.tick);
                chk("err24",  int'(err24),  e.err);
                chk("sec24",  int'(sec24),  e.sec);
                chk("min24",  int'(min24),  e.min);
                chk("hr24",   int'(hr24),   e.hr);
                chk("pm24",   int'(pm24),   e.pm);
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                chk("tick12", int'(tick12), e.tick);
                chk("err12",  int'(err12),  e.err);
                chk("sec12",  int'(sec12),  e.sec);
                chk("min12",  int'(min12),  e.min);
                chk("hr12",   int'(hr12),   e.hr);
                chk("pm12",   int'(pm12),   e.pm);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0);
        repeat (16) step(0, 1, 0, 0, 0);

        // 24h day wrap; also 11:59:59 AM -> 12:00:00 PM in 12h
        set_time(23, 59, 58);
        repeat (8) step(0, 1, 0, 0, 0);
        set_time(11, 59, 59);
        repeat (4) step(0, 1, 0, 0, 0);
        set_time(12, 59, 59);
        repeat (4) step(0, 1, 0, 0, 0);
        set_time(11, 59, 59);
        repeat (4) step(0, 1, 0, 0, 0);

        // rejected requests, including values that would alias after truncation
        step(0, 1, 1, 2'd0, 6'd60);
        step(0, 1, 1, 2'd3, 6'd5);
        step(0, 1, 1, 2'd2, 6'd33);
        step(0, 1, 1, 2'd2, 6'd0);
        step(0, 1, 1, 2'd1, 6'd63);
        repeat (3) step(0, 1, 0, 0, 0);

        // set landing on the terminal-count cycle
        for (int k = 0; k < 4 && mp[0] != 3; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 2'd0, 6'd30);
        repeat (5) step(0, 1, 0, 0, 0);

        // stop mid-second, then resume
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        repeat (8) step(0, 1, 0, 0, 0);

        // reset mid-second discards the partial count
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                 6'($urandom_range(0, 63)));
        end

        for (int k = 0; k < 10 && (q24.size() != 0 || q12.size() != 0); k++) @(negedge clk);
        chk("drain", q24.size() + q12.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
